xcore_bru: RTL and testbench

- Branch Resolution Unit; it is the EX-side counterpart of the static branch predictor.
- Keeps an in-order queue of predictions issued at IF and compares each one with the actual outcome resolved in EX.
- On a mispredict it generates a one-cycle pipeline flush plus a redirect address.
- Owns the IF freeze for JALR: IF is held from JALR fetch until that JALR resolves.

---
 rtl/xcore_pkg.sv | 13 +
 rtl/xcore_bru_fifo.sv | 40 ++++
 rtl/xcore_bru.sv | 83 ++++++++
 tb/tb_xcore_bru.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xcore_pkg.sv
// xcore_pkg: shared opcodes, BRU FSM state encodings and the prediction record layout
package xcore_pkg;
  localparam logic [6:0] B_TYPE = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  typedef enum logic [1:0] {RUN = 2'b00, FREEZE = 2'b01, FLUSH = 2'b10} bru_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic taken;
    logic jalr;
  } bru_rec_t;
endpackage

// File: rtl/xcore_bru_fifo.sv
// xcore_bru_fifo: DEPTH-entry circular FIFO with a synchronous clear that empties it in one edge
module xcore_bru_fifo #(
  parameter int W = 66,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic         bru_clk,
  input  logic         bru_rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         clear,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0] count;
  // pointers and occupancy; a clear discards every entry by collapsing rd onto wr
  always_ff @(posedge bru_clk or negedge bru_rst)
    if (!bru_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (clear) begin
      rd_ptr <= wr_ptr;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  // record storage needs no reset: count gates every read
  always_ff @(posedge bru_clk)
    if (push) mem[wr_ptr] <= push_data;
  assign head = mem[rd_ptr];
  assign full = count == (PTR_W+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/xcore_bru.sv
// xcore_bru: branch resolution unit; optional stat counters under XCORE_BRU_STAT_EN
module xcore_bru
  import xcore_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        bru_clk,
  input  logic        bru_rst,
  input  logic        pred_push_valid,
  input  logic [31:0] pred_push_pc,
  input  logic        pred_push_taken,
  input  logic [31:0] pred_push_target,
  input  logic        pred_push_jalr,
  output logic        pred_full,
  input  logic        res_valid,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic        stall_valid,
  output logic        flush_valid,
  output logic [31:0] redirect_adr,
  output logic        if_freeze,
  output logic        res_mispredict
`ifdef XCORE_BRU_STAT_EN
  ,
  output logic [31:0] stat_resolved,
  output logic [31:0] stat_mispred
`endif
);
  bru_state_e state, state_nxt;
  bru_rec_t push_rec, head;
  logic fifo_full, empty, res_acc, mis, push_acc, jalr_pend;
  logic [31:0] redirect_nxt;
  assign push_rec = '{pc: pred_push_pc, target: pred_push_target, taken: pred_push_taken, jalr: pred_push_jalr};
  assign res_acc = res_valid & ~stall_valid & ~empty;
  assign mis = res_acc & ((res_taken != head.taken) | (res_taken & (res_target != head.target)));
  // a push alongside a pop fits even when full; wrong-path pushes die with the mispredict
  assign push_acc = pred_push_valid & (~fifo_full | res_acc) & (state != FLUSH) & ~mis;
  assign redirect_nxt = res_taken ? res_target : head.pc + 32'd4;
  assign pred_full = fifo_full;
  assign flush_valid = state == FLUSH;
  assign res_mispredict = state == FLUSH;
  assign if_freeze = jalr_pend;
  xcore_bru_fifo #(.W($bits(bru_rec_t)), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .bru_clk  (bru_clk),
    .bru_rst  (bru_rst),
    .push     (push_acc),
    .push_data(push_rec),
    .pop      (res_acc & ~mis),
    .clear    (mis),
    .head     (head),
    .full     (fifo_full),
    .empty    (empty)
  );
  // next state: mispredict wins, FLUSH is a single cycle, JALR push freezes, JALR pop unfreezes
  always_comb
    state_nxt = mis ? FLUSH :
                state == FLUSH ? RUN :
                (state == RUN && push_acc && pred_push_jalr) ? FREEZE :
                (state == FREEZE && res_acc && head.jalr) ? RUN : state;
  // state, outstanding-JALR flag and the redirect target registered for the flush cycle
  always_ff @(posedge bru_clk or negedge bru_rst)
    if (!bru_rst) begin
      state <= RUN;
      jalr_pend <= 1'b0;
      redirect_adr <= '0;
    end else begin
      state <= state_nxt;
      jalr_pend <= (push_acc & pred_push_jalr) | (jalr_pend & ~mis & ~(res_acc & head.jalr));
      redirect_adr <= mis ? redirect_nxt : '0;
    end
`ifdef XCORE_BRU_STAT_EN
  // saturating counts of accepted resolves and mispredicts
  always_ff @(posedge bru_clk or negedge bru_rst)
    if (!bru_rst) begin
      stat_resolved <= '0;
      stat_mispred <= '0;
    end else begin
      if (res_acc && ~&stat_resolved) stat_resolved <= stat_resolved + 32'd1;
      if (mis && ~&stat_mispred) stat_mispred <= stat_mispred + 32'd1;
    end
`endif
endmodule

// File: tb/tb_xcore_bru.sv
// tb_xcore_bru: directed and random checks of xcore_bru against a queue-based reference model
module tb_xcore_bru;
  localparam int DEPTH = 4;
  logic bru_clk, bru_rst;
  logic pred_push_valid, pred_push_taken, pred_push_jalr;
  logic [31:0] pred_push_pc, pred_push_target;
  logic pred_full;
  logic res_valid, res_taken, stall_valid;
  logic [31:0] res_target;
  logic flush_valid, if_freeze, res_mispredict;
  logic [31:0] redirect_adr;
`ifdef XCORE_BRU_STAT_EN
  logic [31:0] stat_resolved, stat_mispred;
  int unsigned m_sr, m_sm;
`endif
  int checks = 0;
  int errors = 0;

  xcore_bru #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .bru_clk         (bru_clk),
    .bru_rst         (bru_rst),
    .pred_push_valid (pred_push_valid),
    .pred_push_pc    (pred_push_pc),
    .pred_push_taken (pred_push_taken),
    .pred_push_target(pred_push_target),
    .pred_push_jalr  (pred_push_jalr),
    .pred_full       (pred_full),
    .res_valid       (res_valid),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .stall_valid     (stall_valid),
    .flush_valid     (flush_valid),
    .redirect_adr    (redirect_adr),
    .if_freeze       (if_freeze),
    .res_mispredict  (res_mispredict)
`ifdef XCORE_BRU_STAT_EN
    ,
    .stat_resolved   (stat_resolved),
    .stat_mispred    (stat_mispred)
`endif
  );

  initial bru_clk = 1'b0;
  always #5 bru_clk = ~bru_clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    bit taken;
    bit jalr;
  } mrec_t;

  mrec_t q[$];
  mrec_t h;
  bit m_flush, m_freeze, ra, mi, pa;
  logic [31:0] m_redir;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  // reference model: an in-order queue of predictions, resolved against the head
  always @(posedge bru_clk or negedge bru_rst) begin
    if (!bru_rst) begin
      q.delete();
      m_flush = 0;
      m_freeze = 0;
      m_redir = 0;
`ifdef XCORE_BRU_STAT_EN
      m_sr = 0;
      m_sm = 0;
`endif
    end else begin
      ra = res_valid && !stall_valid && q.size() != 0;
      mi = 0;
      h = '{pc: 0, target: 0, taken: 0, jalr: 0};
      if (ra) begin
        h = q[0];
        mi = (res_taken != h.taken) || (res_taken && res_target != h.target);
      end
      pa = pred_push_valid && !m_flush && (q.size() < DEPTH || ra) && !mi;
      m_redir = mi ? (res_taken ? res_target : h.pc + 32'd4) : 32'd0;
`ifdef XCORE_BRU_STAT_EN
      if (ra && m_sr != 32'hFFFFFFFF) m_sr++;
      if (mi && m_sm != 32'hFFFFFFFF) m_sm++;
`endif
      if (mi) begin
        q.delete();
        m_freeze = 0;
      end else begin
        if (ra) begin
          void'(q.pop_front());
          if (h.jalr) m_freeze = 0;
        end
        if (pa) begin
          q.push_back('{pc: pred_push_pc, target: pred_push_target, taken: pred_push_taken, jalr: pred_push_jalr});
          if (pred_push_jalr) m_freeze = 1;
        end
      end
      m_flush = mi;
    end
  end

  // every-cycle comparison against the model while out of reset
  always @(negedge bru_clk) begin
    if (bru_rst) begin
      chk("flush_valid", flush_valid, m_flush);
      chk("res_mispredict", res_mispredict, m_flush);
      chk("redirect_adr", redirect_adr, m_redir);
      chk("if_freeze", if_freeze, m_freeze);
      chk("pred_full", pred_full, q.size() == DEPTH);
`ifdef XCORE_BRU_STAT_EN
      chk("stat_resolved", stat_resolved, m_sr);
      chk("stat_mispred", stat_mispred, m_sm);
`endif
    end
  end

  task automatic step(input bit pv, input logic [31:0] pc, input bit tk, input logic [31:0] tg, input bit jl,
                      input bit rv, input bit rtk, input logic [31:0] rtg, input bit st);
    pred_push_valid = pv;
    pred_push_pc = pc;
    pred_push_taken = tk;
    pred_push_target = tg;
    pred_push_jalr = jl;
    res_valid = rv;
    res_taken = rtk;
    res_target = rtg;
    stall_valid = st;
    @(negedge bru_clk);
    pred_push_valid = 0;
    pred_push_jalr = 0;
    res_valid = 0;
    stall_valid = 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] kpc(input int k);
    return 32'h500 + 32'(4 * k);
  endfunction

  function automatic logic [31:0] ktg(input int k);
    return 32'h900 + 32'(4 * k);
  endfunction

  int order[6] = '{0, 1, 2, 3, 5, 6};
  bit rpv, rtk_b, rjl, rrv, rst_b, rtk2;
  logic [31:0] rpc, rtg, rtg2;

  initial begin
    bru_rst = 0;
    pred_push_valid = 0; pred_push_pc = 0; pred_push_taken = 0; pred_push_target = 0; pred_push_jalr = 0;
    res_valid = 0; res_taken = 0; res_target = 0; stall_valid = 0;
    #12;
    chk("reset flush", flush_valid, 0);
    chk("reset freeze", if_freeze, 0);
    chk("reset full", pred_full, 0);
    chk("reset redirect", redirect_adr, 0);
    #10 bru_rst = 1;
    @(negedge bru_clk);
    // correct prediction
    step(1, 32'h100, 1, 32'hF0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 32'hF0, 0);
    chk("correct no flush", flush_valid, 0);
    // direction mispredict
    step(1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 32'h280, 0);
    chk("dir flush", flush_valid, 1);
    chk("dir mispredict", res_mispredict, 1);
    chk("dir redirect", redirect_adr, 32'h280);
    idle();
    chk("dir flush one cycle", flush_valid, 0);
    // reverse mispredict
    step(1, 32'h300, 1, 32'h2C0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("rev redirect", redirect_adr, 32'h304);
    idle();
    // JALR freeze
    step(1, 32'h400, 0, 0, 1, 0, 0, 0, 0);
    chk("jalr freeze on", if_freeze, 1);
    repeat (5) begin
      idle();
      chk("jalr freeze hold", if_freeze, 1);
    end
    step(0, 0, 0, 0, 0, 1, 1, 32'h1000, 0);
    chk("jalr flush", flush_valid, 1);
    chk("jalr redirect", redirect_adr, 32'h1000);
    chk("jalr freeze off", if_freeze, 0);
    idle();
    // full, dropped push, wrap
    for (int k = 0; k < 4; k++) step(1, kpc(k), k[0], ktg(k), 0, 0, 0, 0, 0);
    chk("full after 4", pred_full, 1);
    step(1, kpc(4), 0, ktg(4), 0, 0, 0, 0, 0);
    chk("full after drop", pred_full, 1);
    for (int i = 0; i < 6; i++) begin
      step(1, kpc(5 + i), i[0] ^ 1'b1, ktg(5 + i), 0, 1, order[i][0], ktg(order[i]), 0);
      chk("wrap no flush", flush_valid, 0);
      chk("wrap stays full", pred_full, 1);
    end
    for (int k = 7; k < 11; k++) begin
      step(0, 0, 0, 0, 0, 1, k[0], ktg(k), 0);
      chk("drain no flush", flush_valid, 0);
    end
    chk("drained not full", pred_full, 0);
    // stall and empty resolves are ignored
    step(1, 32'h600, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 32'h700, 1);
    chk("stall ignored", flush_valid, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("post-stall correct", flush_valid, 0);
    step(0, 0, 0, 0, 0, 1, 1, 32'h700, 0);
    chk("empty ignored", flush_valid, 0);
    // asynchronous reset mid-FREEZE
    step(1, 32'h700, 0, 0, 1, 0, 0, 0, 0);
    idle();
    chk("pre-reset freeze", if_freeze, 1);
    #2 bru_rst = 0;
    #1;
    chk("async freeze", if_freeze, 0);
    chk("async full", pred_full, 0);
    chk("async flush", flush_valid, 0);
    @(negedge bru_clk);
    #2 bru_rst = 1;
    @(negedge bru_clk);
    // asynchronous reset during the flush cycle
    step(1, 32'h800, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 32'hA00, 0);
    chk("pre-reset flush", flush_valid, 1);
    #2 bru_rst = 0;
    #1;
    chk("async flush drop", flush_valid, 0);
    chk("async mispredict", res_mispredict, 0);
    chk("async redirect", redirect_adr, 0);
    @(negedge bru_clk);
    #2 bru_rst = 1;
    @(negedge bru_clk);
    // randomized traffic
    repeat (3000) begin
      rpv = $urandom_range(0, 1) == 1;
      rjl = !m_freeze && $urandom_range(0, 9) == 0;
      rpc = $urandom & 32'hFFFF_FFFC;
      rtk_b = rjl ? 1'b0 : ($urandom_range(0, 1) == 1);
      rtg = $urandom_range(0, 1) ? ($urandom & 32'h0000_00F0) : $urandom;
      rrv = $urandom_range(0, 2) != 0;
      rst_b = $urandom_range(0, 4) == 0;
      if (q.size() != 0 && $urandom_range(0, 3) != 0) begin
        rtk2 = q[0].taken;
        rtg2 = q[0].target;
      end else begin
        rtk2 = $urandom_range(0, 1) == 1;
        rtg2 = (q.size() != 0 && $urandom_range(0, 1) == 1) ? q[0].target : ($urandom & 32'h0000_00F0);
      end
      step(rpv, rpc, rtk_b, rtg, rjl, rrv, rtk2, rtg2, rst_b);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
